// File: rtl/accel_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// accel_xfer_ctrl
//
// Purpose:
//   Job-level transfer sequencer for an accelerator. A job moves fill_len
//   words from memory into the input buffer and drain_len words from the
//   output buffer back to memory. The job is cut into bursts of at most
//   BURST_LEN words. Only one burst is outstanding at any time. When fill
//   and drain are both ready to go, they take turns (round-robin).
//
// Parameters:
//   BURST_LEN  maximum words per burst (power of two, 2..128)
//   LEN_W      width of the job length fields
//
// Ports:
//   mem_clk        sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          one-cycle job launch, sampled only when idle
//   fill_len       words memory -> input buffer, captured on accepted start
//   drain_len      words output buffer -> memory, captured on accepted start
//   abort          job cancel request
//   ib_full        input buffer (programmable) full
//   ob_prog_empty  output buffer programmable-empty
//   ob_empty       output buffer hard-empty
//   req_valid      burst request valid
//   req_ready      memory engine accepts the request
//   req_dir        0 = fill (memory read), 1 = drain (memory write)
//   req_len        burst length in words, 1..BURST_LEN
//   burst_done     one-cycle pulse, outstanding burst completed
//   busy           job active
//   done           one-cycle job completion pulse
//   aborted        qualifies done: job was cancelled
//   perf_cycles    busy-cycle counter (zero unless ACCEL_XFER_PERF_EN)
//   perf_stall     ARB no-eligible-requester cycle counter (zero unless
//                  ACCEL_XFER_PERF_EN)
//
// Build option:
//   ACCEL_XFER_PERF_EN  when defined, the two perf counters are implemented.
//                       They clear on reset and on an accepted start, and
//                       they saturate at their maximum value.
// ----------------------------------------------------------------------------
module accel_xfer_ctrl #(
    parameter int BURST_LEN = 16,
    parameter int LEN_W     = 16
) (
    input  logic             mem_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] fill_len,
    input  logic [LEN_W-1:0] drain_len,
    input  logic             abort,
    input  logic             ib_full,
    input  logic             ob_prog_empty,
    input  logic             ob_empty,
    output logic             req_valid,
    input  logic             req_ready,
    output logic             req_dir,
    output logic [7:0]       req_len,
    input  logic             burst_done,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] fill_rem_q;
    logic [LEN_W-1:0] drain_rem_q;
    logic             abort_pend_q;
    logic             last_grant_q;   // 1 = drain was granted last
    logic             req_valid_q;
    logic             req_dir_q;
    logic [7:0]       req_len_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;

    logic             fill_elig;
    logic             drain_elig;
    logic             drain_fits;
    logic             work_left;
    logic             req_dir_d;
    logic [7:0]       req_len_d;

    // Burst length for a remaining word count: min(rem, BURST_LEN).
    function automatic logic [7:0] clip_len(input logic [LEN_W-1:0] rem);
        if (32'(rem) > 32'(BURST_LEN)) begin
            clip_len = 8'(BURST_LEN);
        end else begin
            clip_len = 8'(rem);
        end
    endfunction

    // Eligibility and the grant decision used in ARB.
    always_comb begin
        work_left  = (fill_rem_q != '0) || (drain_rem_q != '0);
        drain_fits = 32'(drain_rem_q) <= 32'(BURST_LEN);
        fill_elig  = (fill_rem_q != '0) && !ib_full;
        // The last (short) drain burst can flush a partly filled output
        // buffer. That buffer will never reach its programmable level, so
        // the drain goes ahead as long as the buffer is not hard-empty.
        drain_elig = (drain_rem_q != '0) &&
                     (!ob_prog_empty || (drain_fits && !ob_empty));
        if (fill_elig && drain_elig) begin
            req_dir_d = ~last_grant_q;
        end else begin
            req_dir_d = drain_elig;
        end
        req_len_d = clip_len(req_dir_d ? drain_rem_q : fill_rem_q);
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fill_rem_q   <= '0;
            drain_rem_q  <= '0;
            abort_pend_q <= 1'b0;
            last_grant_q <= 1'b1;
            req_valid_q  <= 1'b0;
            req_dir_q    <= 1'b0;
            req_len_q    <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        fill_rem_q   <= fill_len;
                        drain_rem_q  <= drain_len;
                        abort_pend_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (abort) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        state_q   <= ST_FIN;
                    end else if (!work_left) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (fill_elig || drain_elig) begin
                        req_valid_q  <= 1'b1;
                        req_dir_q    <= req_dir_d;
                        req_len_q    <= req_len_d;
                        last_grant_q <= req_dir_d;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A handshake in the same cycle as abort still counts.
                    // The abort is then honoured when the burst completes.
                    if (req_ready) begin
                        req_valid_q  <= 1'b0;
                        abort_pend_q <= abort;
                        if (req_dir_q) begin
                            drain_rem_q <= drain_rem_q - LEN_W'(req_len_q);
                        end else begin
                            fill_rem_q <= fill_rem_q - LEN_W'(req_len_q);
                        end
                        state_q <= ST_WAIT;
                    end else if (abort) begin
                        req_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        aborted_q   <= 1'b1;
                        state_q     <= ST_FIN;
                    end
                end
                ST_WAIT: begin
                    if (burst_done) begin
                        abort_pend_q <= 1'b0;
                        if (abort_pend_q || abort) begin
                            done_q    <= 1'b1;
                            aborted_q <= 1'b1;
                            state_q   <= ST_FIN;
                        end else begin
                            state_q <= ST_ARB;
                        end
                    end else if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                end
                ST_FIN: begin
                    busy_q    <= 1'b0;
                    req_dir_q <= 1'b0;
                    req_len_q <= 8'd0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign req_dir   = req_dir_q;
    assign req_len   = req_len_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

`ifdef ACCEL_XFER_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (state_q == ST_IDLE && start) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy_q && perf_cycles_q != '1) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (state_q == ST_ARB && work_left && !fill_elig && !drain_elig &&
                perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`else
    assign perf_cycles = 32'd0;
    assign perf_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_accel_xfer_ctrl.sv
// Bench for accel_xfer_ctrl. A reference model predicts each job's burst
// sequence from the transfer rules. The memory-engine side is driven with
// random handshake and completion delays.
module tb_accel_xfer_ctrl;

    localparam int BL = 16;

    logic        mem_clk, rst_n, start, abort;
    logic        ib_full, ob_prog_empty, ob_empty, req_ready, burst_done;
    logic [15:0] fill_len, drain_len;
    logic        req_valid, req_dir, busy, done, aborted;
    logic [7:0]  req_len;
    logic [31:0] perf_cycles, perf_stall;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state and expectations
    bit m_last_drain;
    bit exp_dir[$];
    int exp_len[$];
    bit exp_aborted;
    bit exp_stall;

    // observations collected by run_job
    bit obs_dir[$];
    int obs_len[$];
    bit obs_done, obs_aborted, obs_timeout, obs_overlap;

    accel_xfer_ctrl #(.BURST_LEN(BL), .LEN_W(16)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .start(start),
        .fill_len(fill_len), .drain_len(drain_len), .abort(abort),
        .ib_full(ib_full), .ob_prog_empty(ob_prog_empty), .ob_empty(ob_empty),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .req_len(req_len), .burst_done(burst_done), .busy(busy), .done(done),
        .aborted(aborted), .perf_cycles(perf_cycles), .perf_stall(perf_stall)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // Predicts the burst list from the job rules, with the buffer flags
    // held static. It stops at a deadlock (abort then expected) or after
    // burst abort_k has handshaken with abort raised.
    function automatic void model_job(input int fl, input int dl, input bit pe,
                                      input bit e, input int abort_k);
        int f = fl;
        int d = dl;
        int len;
        bit fe, de, pick;
        exp_dir.delete();
        exp_len.delete();
        exp_aborted = 0;
        exp_stall   = 0;
        while (f > 0 || d > 0) begin
            fe = (f > 0);
            de = (d > 0) && (!pe || (d <= BL && !e));
            if (!fe && !de) begin
                exp_stall   = 1;
                exp_aborted = 1;
                break;
            end
            if (fe && de) pick = !m_last_drain;
            else          pick = de;
            len = pick ? d : f;
            if (len > BL) len = BL;
            if (pick) d -= len;
            else      f -= len;
            exp_dir.push_back(pick);
            exp_len.push_back(len);
            m_last_drain = pick;
            if (exp_len.size() == abort_k + 1) begin
                exp_aborted = 1;
                break;
            end
        end
    endfunction

    // Launches one job and plays the memory engine until done or a cycle
    // budget runs out. After 6 consecutive cycles with neither a request
    // nor an outstanding burst, it raises abort once.
    task automatic run_job(input int fl, input int dl, input int rdy_max,
                           input int bd_max, input int abort_k);
        int rdy_wait, bd_wait, idle_run, nb;
        bit outst, abort_sent;
        obs_dir.delete();
        obs_len.delete();
        obs_done = 0; obs_aborted = 0; obs_timeout = 0; obs_overlap = 0;
        @(negedge mem_clk);
        start = 1; fill_len = 16'(fl); drain_len = 16'(dl);
        @(negedge mem_clk);
        start = 0;
        rdy_wait = $urandom_range(rdy_max, 0);
        bd_wait = 0; outst = 0; abort_sent = 0; idle_run = 0; nb = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_ready = 0; burst_done = 0; abort = 0;
            if (done) begin
                obs_done = 1;
                obs_aborted = aborted;
                break;
            end
            if (req_valid) begin
                idle_run = 0;
                if (outst) obs_overlap = 1;
                if (rdy_wait == 0) begin
                    req_ready = 1;
                    obs_dir.push_back(req_dir);
                    obs_len.push_back(int'(req_len));
                    if (nb == abort_k) begin
                        abort = 1;
                        abort_sent = 1;
                    end
                    nb++;
                    outst = 1;
                    bd_wait = $urandom_range(bd_max, 0);
                end else begin
                    rdy_wait--;
                    burst_done = ($urandom_range(1, 0) == 1);  // must be ignored
                end
            end else if (outst) begin
                idle_run = 0;
                if (bd_wait == 0) begin
                    burst_done = 1;
                    outst = 0;
                    rdy_wait = $urandom_range(rdy_max, 0);
                end else begin
                    bd_wait--;
                end
            end else begin
                idle_run++;
                burst_done = ($urandom_range(1, 0) == 1);      // must be ignored
                if (idle_run >= 6 && !abort_sent) begin
                    abort = 1;
                    abort_sent = 1;
                end
            end
            @(negedge mem_clk);
        end
        if (!obs_done) obs_timeout = 1;
        req_ready = 0; burst_done = 0; abort = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; abort = 0; ib_full = 0; ob_prog_empty = 0;
        ob_empty = 0; req_ready = 0; burst_done = 0; fill_len = 0; drain_len = 0;
        repeat (3) @(negedge mem_clk);
        n_checks++;
        if ({req_valid, req_dir, req_len, busy, done, aborted} !== 13'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {req_valid, req_dir, req_len, busy, done, aborted});
        else n_pass++;
        n_checks++;
        if ((perf_cycles | perf_stall) !== 32'd0)
            $display("FAIL reset_perf: got %h/%h want 0", perf_cycles, perf_stall);
        else n_pass++;
        rst_n = 1;
        m_last_drain = 1;
        @(negedge mem_clk);
        n_checks++;
        if (busy !== 1'b0 || req_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_release_idle: busy=%b req_valid=%b done=%b want 0",
                     busy, req_valid, done);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int want_dir[4] = '{0, 1, 0, 1};
        model_job(32, 32, 0, 0, -1);
        run_job(32, 32, 1, 3, -1);
        n_checks++;
        if (obs_len.size() !== 4)
            $display("FAIL rr_count: got %0d want 4", obs_len.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < obs_len.size(); i++) begin
            n_checks++;
            if (obs_dir[i] !== want_dir[i][0] || obs_len[i] !== 16)
                $display("FAIL rr_burst%0d: got dir=%0d len=%0d want dir=%0d len=16",
                         i, obs_dir[i], obs_len[i], want_dir[i]);
            else n_pass++;
        end
        n_checks++;
        if (!obs_done || obs_aborted !== 1'b0 || obs_overlap)
            $display("FAIL rr_done: done=%b aborted=%b overlap=%b want 1/0/0",
                     obs_done, obs_aborted, obs_overlap);
        else n_pass++;
    endtask

    task automatic test_fill_only();
        int want_len[3] = '{16, 16, 8};
        model_job(40, 0, 0, 0, -1);
        run_job(40, 0, 0, 3, -1);
        n_checks++;
        if (obs_len.size() !== 3)
            $display("FAIL fill_count: got %0d want 3", obs_len.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < obs_len.size(); i++) begin
            n_checks++;
            if (obs_dir[i] !== 1'b0 || obs_len[i] !== want_len[i])
                $display("FAIL fill_burst%0d: got dir=%0d len=%0d want dir=0 len=%0d",
                         i, obs_dir[i], obs_len[i], want_len[i]);
            else n_pass++;
        end
        n_checks++;
        if (!obs_done || obs_aborted !== 1'b0)
            $display("FAIL fill_done: done=%b aborted=%b want 1/0", obs_done, obs_aborted);
        else n_pass++;
        @(negedge mem_clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL fill_single_done: done=%b busy=%b want 0/0", done, busy);
        else n_pass++;
    endtask

    task automatic test_drain_small();
        ob_prog_empty = 1; ob_empty = 0;
        model_job(0, 5, 1, 0, -1);
        run_job(0, 5, 1, 2, -1);
        n_checks++;
        if (obs_len.size() !== 1 || (obs_len.size() == 1 &&
            (obs_dir[0] !== 1'b1 || obs_len[0] !== 5)))
            $display("FAIL drain_small_burst: got %0d bursts (first len=%0d) want 1 drain of 5",
                     obs_len.size(), (obs_len.size() > 0) ? obs_len[0] : -1);
        else n_pass++;
        n_checks++;
        if (!obs_done || obs_aborted !== 1'b0)
            $display("FAIL drain_small_done: done=%b aborted=%b want 1/0",
                     obs_done, obs_aborted);
        else n_pass++;
        ob_empty = 1;
        model_job(0, 5, 1, 1, -1);
        run_job(0, 5, 1, 2, -1);
        n_checks++;
        if (obs_len.size() !== 0)
            $display("FAIL drain_empty_noreq: got %0d bursts want 0", obs_len.size());
        else n_pass++;
        n_checks++;
        if (!obs_done || obs_aborted !== 1'b1)
            $display("FAIL drain_empty_abort: done=%b aborted=%b want 1/1",
                     obs_done, obs_aborted);
        else n_pass++;
        ob_prog_empty = 0; ob_empty = 0;
    endtask

    task automatic test_abort_issue();
        @(negedge mem_clk);
        start = 1; fill_len = 16; drain_len = 0; req_ready = 0;
        @(negedge mem_clk);
        start = 0;
        @(negedge mem_clk);
        n_checks++;
        if (req_valid !== 1'b1 || req_dir !== 1'b0 || req_len !== 8'd16)
            $display("FAIL abort_issue_req: valid=%b dir=%b len=%0d want 1/0/16",
                     req_valid, req_dir, req_len);
        else n_pass++;
        m_last_drain = 0;
        @(negedge mem_clk);
        abort = 1;
        @(negedge mem_clk);
        abort = 0;
        n_checks++;
        if (req_valid !== 1'b0 || done !== 1'b1 || aborted !== 1'b1)
            $display("FAIL abort_issue_fin: valid=%b done=%b aborted=%b want 0/1/1",
                     req_valid, done, aborted);
        else n_pass++;
        @(negedge mem_clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || req_valid !== 1'b0)
            $display("FAIL abort_issue_idle: done=%b busy=%b valid=%b want 0/0/0",
                     done, busy, req_valid);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        @(negedge mem_clk);
        start = 1; fill_len = 0; drain_len = 0;
        @(negedge mem_clk);
        start = 0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || req_valid !== 1'b0)
            $display("FAIL zero_len_cycle1: done=%b busy=%b valid=%b want 0/1/0",
                     done, busy, req_valid);
        else n_pass++;
        @(negedge mem_clk);
        n_checks++;
        if (done !== 1'b1 || aborted !== 1'b0 || req_valid !== 1'b0)
            $display("FAIL zero_len_done: done=%b aborted=%b valid=%b want 1/0/0",
                     done, aborted, req_valid);
        else n_pass++;
        @(negedge mem_clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL zero_len_idle: done=%b busy=%b want 0/0", done, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int n;
        @(negedge mem_clk);
        start = 1; fill_len = 20; drain_len = 0;
        @(negedge mem_clk);
        start = 0;
        n = 0;
        while (!req_valid && n < 10) begin
            @(negedge mem_clk);
            n++;
        end
        n_checks++;
        if (req_valid !== 1'b1)
            $display("FAIL midrst_req: req_valid=%b want 1", req_valid);
        else n_pass++;
        req_ready = 1;
        @(negedge mem_clk);
        req_ready = 0;
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({req_valid, req_dir, req_len, busy, done, aborted} !== 13'd0)
            $display("FAIL midrst_outputs: got %h want 0",
                     {req_valid, req_dir, req_len, busy, done, aborted});
        else n_pass++;
        burst_done = 1;
        @(negedge mem_clk);
        burst_done = 0;
        rst_n = 1;
        m_last_drain = 1;
        @(negedge mem_clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL midrst_nodone: done=%b busy=%b want 0/0", done, busy);
        else n_pass++;
        model_job(20, 3, 0, 0, -1);
        run_job(20, 3, 2, 3, -1);
        n_checks++;
        if (obs_len.size() !== exp_len.size())
            $display("FAIL midrst_rerun_count: got %0d want %0d",
                     obs_len.size(), exp_len.size());
        else n_pass++;
        for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
            n_checks++;
            if (obs_dir[i] !== exp_dir[i] || obs_len[i] !== exp_len[i])
                $display("FAIL midrst_rerun_burst%0d: got dir=%0d len=%0d want dir=%0d len=%0d",
                         i, obs_dir[i], obs_len[i], exp_dir[i], exp_len[i]);
            else n_pass++;
        end
        n_checks++;
        if (!obs_done || obs_aborted !== 1'b0)
            $display("FAIL midrst_rerun_done: done=%b aborted=%b want 1/0",
                     obs_done, obs_aborted);
        else n_pass++;
    endtask

    task automatic test_random();
        int fl, dl, ak;
        bit pe, e;
        for (int j = 0; j < 16; j++) begin
            fl = $urandom_range(60, 0);
            dl = $urandom_range(60, 0);
            pe = ($urandom_range(1, 0) == 1);
            e  = ($urandom_range(3, 0) == 0);
            ak = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 0)) : -1;
            ob_prog_empty = pe; ob_empty = e; ib_full = 0;
            model_job(fl, dl, pe, e, ak);
            run_job(fl, dl, 3, 4, ak);
            n_checks++;
            if (obs_len.size() !== exp_len.size())
                $display("FAIL rand%0d_count: got %0d want %0d (fl=%0d dl=%0d pe=%0d e=%0d ak=%0d)",
                         j, obs_len.size(), exp_len.size(), fl, dl, pe, e, ak);
            else n_pass++;
            for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
                n_checks++;
                if (obs_dir[i] !== exp_dir[i] || obs_len[i] !== exp_len[i])
                    $display("FAIL rand%0d_burst%0d: got dir=%0d len=%0d want dir=%0d len=%0d",
                             j, i, obs_dir[i], obs_len[i], exp_dir[i], exp_len[i]);
                else n_pass++;
            end
            n_checks++;
            if (obs_timeout || obs_overlap || obs_aborted !== exp_aborted)
                $display("FAIL rand%0d_end: timeout=%b overlap=%b aborted=%b want 0/0/%b",
                         j, obs_timeout, obs_overlap, obs_aborted, exp_aborted);
            else n_pass++;
            @(negedge mem_clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL rand%0d_idle: done=%b busy=%b want 0/0", j, done, busy);
            else n_pass++;
        end
        ob_prog_empty = 0; ob_empty = 0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fill_only();
        test_drain_small();
        test_abort_issue();
        test_zero_len();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/accel_xfer_ctrl.md
ACCEL_XFER_CTRL -- requirements
Module: accel_xfer_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, maximum words per memory burst (power of two, 2..128).
REQ-002 SHALL have parameter LEN_W, default 16, width of the transfer-length fields.
REQ-003 SHALL have port mem_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle job launch, sampled only in IDLE.
REQ-006 SHALL have port fill_len  input  LEN_W  words to move memory->input buffer, captured on accepted start.
REQ-007 SHALL have port drain_len  input  LEN_W  words to move output buffer->memory, captured on accepted start.
REQ-008 SHALL have port abort  input  1  job cancel request.
REQ-009 SHALL have port ib_full  input  1  input-buffer (programmable) full flag.
REQ-010 SHALL have port ob_prog_empty  input  1  output-buffer programmable-empty flag.
REQ-011 SHALL have port ob_empty  input  1  output-buffer hard-empty flag.
REQ-012 SHALL have port req_valid  output  1  burst request valid.
REQ-013 SHALL have port req_ready  input  1  memory engine accepts the request.
REQ-014 SHALL have port req_dir  output  1  0 = fill (mem read), 1 = drain (mem write).
REQ-015 SHALL have port req_len  output  8  burst length in words, 1..BURST_LEN.
REQ-016 SHALL have port burst_done  input  1  one-cycle pulse: outstanding burst completed.
REQ-017 SHALL have ports busy (output 1, job active), done (output 1, one-cycle completion pulse), aborted (output 1, valid with done).

Function
REQ-018 SHALL implement FSM states IDLE, ARB, ISSUE, WAIT, FIN.
REQ-019 IDLE: start=1 SHALL capture fill_len/drain_len into fill_rem/drain_rem and go to ARB; start outside IDLE SHALL be ignored.
REQ-020 ARB: fill eligible = fill_rem>0 & !ib_full; drain eligible = drain_rem>0 & (!ob_prog_empty | (drain_rem<=BURST_LEN & !ob_empty)).
REQ-021 ARB: one eligible -> grant it; both -> grant the one not granted last (round-robin, last_grant resets to drain so fill wins first); none -> stay ARB.
REQ-022 ARB: fill_rem=0 & drain_rem=0 (including zero-length start) SHALL go to FIN.
REQ-023 On grant SHALL go to ISSUE with req_len = min(rem, BURST_LEN), req_dir per grant; ARB->ISSUE one cycle.
REQ-024 ISSUE: req_valid=1, req_dir/req_len stable until req_valid&req_ready; on that edge rem -= req_len, go to WAIT.
REQ-025 WAIT: exactly one burst outstanding; on burst_done go to ARB (or FIN if abort pending).
REQ-026 burst_done outside WAIT SHALL be ignored.
REQ-027 FIN: done=1 for one cycle, aborted=1 iff job was aborted, then IDLE.
REQ-028 abort in ARB or ISSUE (before handshake) SHALL go to FIN next cycle, req_valid deasserting; abort in WAIT SHALL be latched and honoured at burst_done; abort in IDLE/FIN ignored.
REQ-029 abort and req_ready in the same ISSUE cycle: handshake wins, burst counts, go to WAIT with abort pending.
REQ-030 busy=1 in every state except IDLE.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, fill_rem=drain_rem=0, abort-pending=0, last_grant=drain.
REQ-032 During/after reset: req_valid=0, req_dir=0, req_len=0, busy=0, done=0, aborted=0; reset mid-burst drops the job, no done pulse.

Configuration
REQ-033 With macro ACCEL_XFER_PERF_EN defined SHALL add outputs perf_cycles[31:0] (cycles with busy=1) and perf_stall[31:0] (cycles in ARB with no eligible requester), cleared on reset and on accepted start, saturating at max.
REQ-034 Without ACCEL_XFER_PERF_EN both ports SHALL exist and be tied to 0, no counter logic.

Verification
REQ-035 fill_len=40, drain_len=0, BURST_LEN=16, req_ready=1, flags clear -> fill bursts of 16,16,8 then single done, aborted=0.
REQ-036 fill_len=32, drain_len=32, all eligible -> req_dir sequence 0,1,0,1, each len 16.
REQ-037 drain_len=5, ob_prog_empty=1, ob_empty=0 -> one drain burst len 5; with ob_empty=1 -> stays ARB, no request.
REQ-038 fill_len=16, req_ready held low 4 cycles, abort on cycle 2 -> req_valid drops, done+aborted pulse, no handshake.
REQ-039 start with fill_len=drain_len=0 -> done pulse 2 cycles later, no req_valid.
REQ-040 rst_n low during WAIT -> all outputs 0 immediately; subsequent start runs cleanly.
